// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer controllers
// (write-side full/count block and read-side empty/count block).
package fifo_pkg;

    localparam int DEFAULT_ADDRSIZE = 8;

    // Pointers are ADDRSIZE+1 bits: the extra MSB tells a full FIFO from an empty one.
    // Packages cannot take parameters, so this is the default-width pointer type;
    // controllers declare their own instance-width type with the same shape.
    typedef logic [DEFAULT_ADDRSIZE:0] ptr_t;

    // Wide carrier so bin2gray serves any pointer width up to 32 bits.
    // Zero-extension does not change the low-order Gray bits, so callers
    // simply truncate the result back to their own width.
    localparam int PTR_WIDE_W = 32;
    typedef logic [PTR_WIDE_W-1:0] ptr_wide_t;

    function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter, purely combinational.
// Each binary bit is the XOR of all Gray bits from the MSB down to its position.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Prefix XOR from the MSB down to bit i
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and status controller for the asynchronous FIFO.
// Keeps the binary/Gray write pointers and derives full, fill level,
// almost-full and a sticky overflow flag from the synchronised read pointer.
// Status is pessimistic: wq2_rptr lags real reads, so fill may be overstated
// but never understated.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = DEFAULT_ADDRSIZE
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   wafull_thresh,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wcount,
    output logic                woverflow
);

    localparam int PW = ADDRSIZE + 1;

    typedef logic [ADDRSIZE:0] wptr_t;

    wptr_t wbin;
    wptr_t wbinnext;
    wptr_t wgraynext;
    wptr_t rbin;
    wptr_t wcount_next;
    logic  winc_ok;
    logic  wfull_val;
    logic  wafull_val;

    gray2bin #(
        .WIDTH (PW)
    ) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    // A write is accepted only while the registered full flag is low; a
    // rejected write leaves the pointers untouched.
    assign winc_ok   = winc & ~wfull;
    assign wbinnext  = wbin + wptr_t'(winc_ok);
    assign wgraynext = wptr_t'(bin2gray(ptr_wide_t'(wbinnext)));

    // Modulo subtraction stays correct across pointer wrap-around.
    assign wcount_next = wbinnext - rbin;

    // Full when the next write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that means the top two bits differ, the rest match.
    assign wfull_val  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    assign wafull_val = (wcount_next >= wafull_thresh);

    assign waddr = wbin[ADDRSIZE-1:0];

    // Pointer and status registers, all updated together so flags track the pointer with no lag
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin   <= '0;
            wptr   <= '0;
            wcount <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wcount <= wcount_next;
            wfull  <= wfull_val;
            wafull <= wafull_val;
        end
    end

    // Sticky overflow: a write attempt while full wins over a clear in the same cycle
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
        end else if (winc && wfull) begin
            woverflow <= 1'b1;
        end else if (wovf_clr) begin
            woverflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl at ADDRSIZE=3 (DEPTH=8).
module tb_wptr_full_ctrl;

    localparam int AS = 3;

    logic          wclk;
    logic          wrst_n;
    logic          winc;
    logic [AS:0]   wq2_rptr;
    logic [AS:0]   wafull_thresh;
    logic          wovf_clr;
    logic [AS-1:0] waddr;
    logic [AS:0]   wptr;
    logic          wfull;
    logic          wafull;
    logic [AS:0]   wcount;
    logic          woverflow;

    int checks = 0;
    int errors = 0;

    wptr_full_ctrl #(
        .ADDRSIZE (AS)
    ) dut (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .winc          (winc),
        .wq2_rptr      (wq2_rptr),
        .wafull_thresh (wafull_thresh),
        .wovf_clr      (wovf_clr),
        .waddr         (waddr),
        .wptr          (wptr),
        .wfull         (wfull),
        .wafull        (wafull),
        .wcount        (wcount),
        .woverflow     (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [AS:0] g(input logic [AS:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_waddr"}, 32'(waddr), 0);
        chk({tag, "_wptr"}, 32'(wptr), 0);
        chk({tag, "_wcount"}, 32'(wcount), 0);
        chk({tag, "_wfull"}, 32'(wfull), 0);
        chk({tag, "_wafull"}, 32'(wafull), 0);
        chk({tag, "_wovf"}, 32'(woverflow), 0);
    endtask

    initial begin
        logic [AS:0] cur;
        logic [AS:0] prev_b;
        logic [AS:0] nxt;

        wrst_n        = 1'b0;
        winc          = 1'b0;
        wq2_rptr      = '0;
        wafull_thresh = 4'd6;
        wovf_clr      = 1'b0;
        #3;
        chk_all_zero("rst_async");
        repeat (2) @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        edge1();
        chk_all_zero("rst_rel");

        // Fill 8 entries with threshold 6
        for (int i = 1; i <= 8; i++) begin
            winc = 1'b1;
            edge1();
            chk("fill_wcount", 32'(wcount), 32'(i));
            chk("fill_wafull", 32'(wafull), (i >= 6) ? 1 : 0);
            chk("fill_wfull", 32'(wfull), (i == 8) ? 1 : 0);
        end
        chk("fill_wptr", 32'(wptr), 32'hC);
        chk("fill_waddr", 32'(waddr), 0);

        // Overflow: three writes while full
        for (int i = 0; i < 3; i++) begin
            winc = 1'b1;
            edge1();
            chk("ovf_wptr", 32'(wptr), 32'hC);
            chk("ovf_wcount", 32'(wcount), 8);
            chk("ovf_flag", 32'(woverflow), 1);
        end
        wovf_clr = 1'b1;
        winc     = 1'b1;
        edge1();
        chk("ovf_clr_vs_set", 32'(woverflow), 1);
        winc = 1'b0;
        edge1();
        chk("ovf_clr", 32'(woverflow), 0);
        wovf_clr = 1'b0;

        // Drain: read side reaches binary 2
        wafull_thresh = 4'd7;
        wq2_rptr      = 4'b0011;
        edge1();
        chk("drain_wfull", 32'(wfull), 0);
        chk("drain_wcount", 32'(wcount), 6);
        chk("drain_wafull", 32'(wafull), 0);

        // Refill to full (wbin 10), then write and read advance together
        winc = 1'b1;
        edge1();
        edge1();
        chk("refill_wfull", 32'(wfull), 1);
        chk("refill_wcount", 32'(wcount), 8);
        chk("refill_wptr", 32'(wptr), 32'hF);
        winc     = 1'b1;
        wq2_rptr = 4'b0010;
        edge1();
        chk("simul_wptr", 32'(wptr), 32'hF);
        chk("simul_wfull", 32'(wfull), 0);
        chk("simul_wcount", 32'(wcount), 7);
        chk("simul_wovf", 32'(woverflow), 1);
        winc = 1'b1;
        edge1();
        chk("simul_next_wcount", 32'(wcount), 8);
        chk("simul_next_wfull", 32'(wfull), 1);
        chk("simul_next_wptr", 32'(wptr), 32'hE);

        // Wrap: read pointer catches up, then follows one register stage behind
        winc     = 1'b0;
        wq2_rptr = 4'b1110;
        edge1();
        chk("wrap_pre_wcount", 32'(wcount), 0);
        cur    = 4'd11;
        prev_b = 4'd11;
        for (int k = 0; k < 20; k++) begin
            wq2_rptr = g(prev_b);
            winc     = 1'b1;
            edge1();
            nxt = cur + 4'd1;
            chk("wrap_wcount", 32'(wcount), 32'(4'(nxt - prev_b)));
            chk("wrap_wcount_le2", (wcount <= 4'd2) ? 32'd1 : 32'd0, 1);
            chk("wrap_wfull", 32'(wfull), 0);
            chk("wrap_waddr", 32'(waddr), 32'(nxt[AS-1:0]));
            chk("wrap_wptr", 32'(wptr), 32'(g(nxt)));
            prev_b = cur;
            cur    = nxt;
        end

        // Reset in mid-operation after 5 writes
        winc     = 1'b0;
        wq2_rptr = g(cur);
        edge1();
        for (int i = 0; i < 5; i++) begin
            winc = 1'b1;
            edge1();
        end
        winc = 1'b0;
        chk("mid_pre_wcount", 32'(wcount), 5);
        chk("mid_pre_wovf", 32'(woverflow), 1);
        @(posedge wclk);
        #3;
        wrst_n   = 1'b0;
        wq2_rptr = '0;
        #1;
        chk_all_zero("mid_rst");
        @(negedge wclk);
        wrst_n = 1'b1;
        winc   = 1'b1;
        edge1();
        chk("mid_post_waddr", 32'(waddr), 1);
        chk("mid_post_wcount", 32'(wcount), 1);
        chk("mid_post_wptr", 32'(wptr), 1);

        // Threshold above DEPTH never asserts almost-full
        wafull_thresh = 4'd9;
        for (int i = 2; i <= 8; i++) begin
            winc = 1'b1;
            edge1();
            chk("th9_wafull", 32'(wafull), 0);
        end
        chk("th9_wfull", 32'(wfull), 1);
        chk("th9_wcount", 32'(wcount), 8);

        // Threshold 0 asserts almost-full from the first edge after reset
        winc          = 1'b0;
        wafull_thresh = 4'd0;
        #2;
        wrst_n = 1'b0;
        #1;
        chk("th0_rst_wafull", 32'(wafull), 0);
        @(negedge wclk);
        wrst_n = 1'b1;
        edge1();
        chk("th0_wafull", 32'(wafull), 1);
        chk("th0_wcount", 32'(wcount), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
